// File: rtl/pipe_ctrl.sv
// Handshake and hazard controller for a 5-stage IF/ID/EXE/MEM/WB pipeline.
// Owns the stage valid bits, load enables, data-hazard stalls, branch flush and DRAM wait.
module pipe_ctrl #(
    parameter int unsigned DRAM_LAT = 1,
    parameter int unsigned FORWARD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_ready_go,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] exe_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       exe_ref_we,
    input  logic       mem_ref_we,
    input  logic       wb_ref_we,
    input  logic       exe_res_from_dram,
    input  logic       mem_res_from_dram,
    input  logic       exe_br_taken,
    input  logic       mem_dram_re,
    input  logic       mem_dram_we,
    output logic       pc_we,
    output logic       pc_sel_br,
    output logic       if_to_id_go,
    output logic       id_to_exe_go,
    output logic       exe_to_mem_go,
    output logic       mem_to_wb_go,
    output logic       id_valid,
    output logic       exe_valid,
    output logic       mem_valid,
    output logic       wb_valid,
    output logic       id_stall,
    output logic [0:0] mem_state,
    output logic [3:0] dram_cnt
);

    // Handshake: a stage hands its instruction on when it is valid, its ready_go is high
    // and the receiving stage's allowin is high; allowin = !valid | (ready_go & allowin_next).
    // A stage that is not valid always accepts, so bubbles never block the pipe.

    localparam logic [0:0] M_IDLE = 1'b0;
    localparam logic [0:0] M_WAIT = 1'b1;

    localparam logic [3:0] LAT_LAST  = 4'(DRAM_LAT - 1);
    localparam bit         SLOW_DRAM = (DRAM_LAT > 1);
    localparam bit         HAS_FWD   = (FORWARD != 0);

    logic [0:0] state;
    logic [3:0] cnt;

    logic acc;
    logic mem_ready_go;
    logic id_ready_go;
    logic id_allowin;
    logic exe_allowin;
    logic mem_allowin;
    logic br_flush;

    logic rs1_live;
    logic rs2_live;
    logic exe_match;
    logic mem_match;
    logic wb_match;
    logic haz_fwd;
    logic haz_all;
    logic hazard;

    // ---------------- DRAM wait FSM ----------------
    assign acc = mem_valid & (mem_dram_re | mem_dram_we);

    always_comb begin
        mem_ready_go = 1'b1;
        case (state)
            M_IDLE:  mem_ready_go = !acc || !SLOW_DRAM;
            M_WAIT:  mem_ready_go = (cnt == LAT_LAST);
            default: mem_ready_go = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= M_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (acc && SLOW_DRAM) begin
                        state <= M_WAIT;
                        cnt   <= 4'd1;
                    end
                end
                M_WAIT: begin
                    // cnt stops at LAT_LAST because reaching it releases MEM
                    if (mem_ready_go) begin
                        state <= M_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= M_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign mem_state = state;
    assign dram_cnt  = cnt;

    // ---------------- Data hazard detection ----------------
    assign rs1_live  = id_rs1_used & (id_rs1 != 5'd0);
    assign rs2_live  = id_rs2_used & (id_rs2 != 5'd0);

    assign exe_match = (rs1_live & (id_rs1 == exe_rd)) | (rs2_live & (id_rs2 == exe_rd));
    assign mem_match = (rs1_live & (id_rs1 == mem_rd)) | (rs2_live & (id_rs2 == mem_rd));
    assign wb_match  = (rs1_live & (id_rs1 == wb_rd))  | (rs2_live & (id_rs2 == wb_rd));

    // With bypassing only load data that does not exist yet forces a stall
    assign haz_fwd = (exe_valid & exe_ref_we & exe_res_from_dram & exe_match)
                   | (mem_valid & mem_ref_we & mem_res_from_dram & !mem_ready_go & mem_match);

    assign haz_all = (exe_valid & exe_ref_we & exe_match)
                   | (mem_valid & mem_ref_we & mem_match)
                   | (wb_valid  & wb_ref_we  & wb_match);

    assign hazard = HAS_FWD ? haz_fwd : haz_all;

    // ---------------- Allowin chain and flush ----------------
    assign mem_allowin = !mem_valid | mem_ready_go;
    assign exe_allowin = !exe_valid | mem_allowin;

    // A taken branch only flushes once it can itself move into MEM
    assign br_flush    = exe_valid & exe_br_taken & mem_allowin;

    // The wrong-path ID instruction is squashed on a flush, so its hazard is irrelevant
    assign id_ready_go = !hazard | br_flush;
    assign id_allowin  = !id_valid | (id_ready_go & exe_allowin);
    assign id_stall    = id_valid & hazard & !br_flush;

    assign if_to_id_go   = id_allowin;
    assign id_to_exe_go  = exe_allowin;
    assign exe_to_mem_go = mem_allowin;
    assign mem_to_wb_go  = 1'b1;

    assign pc_we     = (if_ready_go & id_allowin) | br_flush;
    assign pc_sel_br = br_flush;

    // ---------------- Stage valid bits ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid  <= 1'b0;
            exe_valid <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if (id_allowin) begin
                id_valid <= if_ready_go & !br_flush;
            end
            if (exe_allowin) begin
                exe_valid <= id_valid & id_ready_go & !br_flush;
            end
            if (mem_allowin) begin
                mem_valid <= exe_valid;
            end
            wb_valid <= mem_valid & mem_ready_go;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three instances (LAT1/FWD, LAT3/FWD, LAT1/no-FWD)
// share one input stream; each scenario checks the instance it targets.
module tb_pipe_ctrl;

    localparam int A = 0;  // DRAM_LAT=1, FORWARD=1
    localparam int B = 1;  // DRAM_LAT=3, FORWARD=1
    localparam int C = 2;  // DRAM_LAT=1, FORWARD=0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       if_ready_go;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] exe_rd, mem_rd, wb_rd;
    logic       exe_ref_we, mem_ref_we, wb_ref_we;
    logic       exe_res_from_dram, mem_res_from_dram;
    logic       exe_br_taken;
    logic       mem_dram_re, mem_dram_we;

    logic       pc_we         [3];
    logic       pc_sel_br     [3];
    logic       if_to_id_go   [3];
    logic       id_to_exe_go  [3];
    logic       exe_to_mem_go [3];
    logic       mem_to_wb_go  [3];
    logic       id_valid      [3];
    logic       exe_valid     [3];
    logic       mem_valid     [3];
    logic       wb_valid      [3];
    logic       id_stall      [3];
    logic [0:0] mem_state     [3];
    logic [3:0] dram_cnt      [3];

    int tests = 0;
    int fails = 0;

    pipe_ctrl #(.DRAM_LAT(1), .FORWARD(1)) u_a (
        .clk(clk), .rst(rst), .if_ready_go(if_ready_go),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_ref_we(exe_ref_we), .mem_ref_we(mem_ref_we), .wb_ref_we(wb_ref_we),
        .exe_res_from_dram(exe_res_from_dram), .mem_res_from_dram(mem_res_from_dram),
        .exe_br_taken(exe_br_taken), .mem_dram_re(mem_dram_re), .mem_dram_we(mem_dram_we),
        .pc_we(pc_we[A]), .pc_sel_br(pc_sel_br[A]),
        .if_to_id_go(if_to_id_go[A]), .id_to_exe_go(id_to_exe_go[A]),
        .exe_to_mem_go(exe_to_mem_go[A]), .mem_to_wb_go(mem_to_wb_go[A]),
        .id_valid(id_valid[A]), .exe_valid(exe_valid[A]), .mem_valid(mem_valid[A]),
        .wb_valid(wb_valid[A]), .id_stall(id_stall[A]),
        .mem_state(mem_state[A]), .dram_cnt(dram_cnt[A])
    );

    pipe_ctrl #(.DRAM_LAT(3), .FORWARD(1)) u_b (
        .clk(clk), .rst(rst), .if_ready_go(if_ready_go),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_ref_we(exe_ref_we), .mem_ref_we(mem_ref_we), .wb_ref_we(wb_ref_we),
        .exe_res_from_dram(exe_res_from_dram), .mem_res_from_dram(mem_res_from_dram),
        .exe_br_taken(exe_br_taken), .mem_dram_re(mem_dram_re), .mem_dram_we(mem_dram_we),
        .pc_we(pc_we[B]), .pc_sel_br(pc_sel_br[B]),
        .if_to_id_go(if_to_id_go[B]), .id_to_exe_go(id_to_exe_go[B]),
        .exe_to_mem_go(exe_to_mem_go[B]), .mem_to_wb_go(mem_to_wb_go[B]),
        .id_valid(id_valid[B]), .exe_valid(exe_valid[B]), .mem_valid(mem_valid[B]),
        .wb_valid(wb_valid[B]), .id_stall(id_stall[B]),
        .mem_state(mem_state[B]), .dram_cnt(dram_cnt[B])
    );

    pipe_ctrl #(.DRAM_LAT(1), .FORWARD(0)) u_c (
        .clk(clk), .rst(rst), .if_ready_go(if_ready_go),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_ref_we(exe_ref_we), .mem_ref_we(mem_ref_we), .wb_ref_we(wb_ref_we),
        .exe_res_from_dram(exe_res_from_dram), .mem_res_from_dram(mem_res_from_dram),
        .exe_br_taken(exe_br_taken), .mem_dram_re(mem_dram_re), .mem_dram_we(mem_dram_we),
        .pc_we(pc_we[C]), .pc_sel_br(pc_sel_br[C]),
        .if_to_id_go(if_to_id_go[C]), .id_to_exe_go(id_to_exe_go[C]),
        .exe_to_mem_go(exe_to_mem_go[C]), .mem_to_wb_go(mem_to_wb_go[C]),
        .id_valid(id_valid[C]), .exe_valid(exe_valid[C]), .mem_valid(mem_valid[C]),
        .wb_valid(wb_valid[C]), .id_stall(id_stall[C]),
        .mem_state(mem_state[C]), .dram_cnt(dram_cnt[C])
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_ready_go       = 1'b0;
        id_rs1            = 5'd0;
        id_rs2            = 5'd0;
        id_rs1_used       = 1'b0;
        id_rs2_used       = 1'b0;
        exe_rd            = 5'd0;
        mem_rd            = 5'd0;
        wb_rd             = 5'd0;
        exe_ref_we        = 1'b0;
        mem_ref_we        = 1'b0;
        wb_ref_we         = 1'b0;
        exe_res_from_dram = 1'b0;
        mem_res_from_dram = 1'b0;
        exe_br_taken      = 1'b0;
        mem_dram_re       = 1'b0;
        mem_dram_we       = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        clear_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // ---- reset state ----
        rst = 1'b0;
        clear_inputs();
        if_ready_go = 1'b1;
        #2;
        chk("rst pc_we",         pc_we[A],         1'b1);
        chk("rst pc_sel_br",     pc_sel_br[A],     1'b0);
        chk("rst if_to_id_go",   if_to_id_go[A],   1'b1);
        chk("rst id_to_exe_go",  id_to_exe_go[A],  1'b1);
        chk("rst exe_to_mem_go", exe_to_mem_go[A], 1'b1);
        chk("rst mem_to_wb_go",  mem_to_wb_go[A],  1'b1);
        chk("rst id_valid",      id_valid[B],      1'b0);
        chk("rst exe_valid",     exe_valid[B],     1'b0);
        chk("rst mem_valid",     mem_valid[B],     1'b0);
        chk("rst wb_valid",      wb_valid[B],      1'b0);
        chk("rst id_stall",      id_stall[C],      1'b0);
        chk("rst mem_state",     mem_state[B],     4'd0);
        chk("rst dram_cnt",      dram_cnt[B],      4'd0);
        if_ready_go = 1'b0;
        #1;
        chk("rst pc_we idle",    pc_we[A],         1'b0);

        // ---- 1: five straight-line adds, one retire per cycle ----
        do_reset();
        id_rs1 = 5'd7;  id_rs1_used = 1'b1;
        exe_rd = 5'd1;  exe_ref_we  = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            if_ready_go = (e <= 5);
            #1;
            chk($sformatf("t1 pc_we e%0d", e),    pc_we[A],    (e <= 5));
            chk($sformatf("t1 id_stall e%0d", e), id_stall[A], 1'b0);
            tick();
            chk($sformatf("t1 id_valid e%0d", e), id_valid[A], (e <= 5));
            chk($sformatf("t1 wb_valid e%0d", e), wb_valid[A], (e >= 4 && e <= 8));
        end

        // ---- 2: ld x3 ; add x4,x3,x3 with bypassing ----
        do_reset();
        if_ready_go = 1'b1;
        tick();                                   // ld in ID
        tick();                                   // ld in EXE, add in ID
        exe_rd = 5'd3; exe_ref_we = 1'b1; exe_res_from_dram = 1'b1;
        id_rs1 = 5'd3; id_rs2 = 5'd3; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        #1;
        chk("t2 id_stall",      id_stall[A],     1'b1);
        chk("t2 pc_we",         pc_we[A],        1'b0);
        chk("t2 if_to_id_go",   if_to_id_go[A],  1'b0);
        chk("t2 id_to_exe_go",  id_to_exe_go[A], 1'b1);
        tick();                                   // ld in MEM, bubble in EXE
        chk("t2 bubble exe_valid", exe_valid[A], 1'b0);
        chk("t2 held id_valid",    id_valid[A],  1'b1);
        chk("t2 ld mem_valid",     mem_valid[A], 1'b1);
        exe_ref_we = 1'b0; exe_res_from_dram = 1'b0;
        mem_rd = 5'd3; mem_ref_we = 1'b1; mem_res_from_dram = 1'b1; mem_dram_re = 1'b1;
        if_ready_go = 1'b0;
        #1;
        chk("t2 released id_stall", id_stall[A], 1'b0);
        tick();
        chk("t2 add exe_valid", exe_valid[A], 1'b1);
        chk("t2 ld wb_valid",   wb_valid[A],  1'b1);
        chk("t2 id_valid",      id_valid[A],  1'b0);

        // ---- 3: DRAM_LAT=3 load holds MEM for three cycles ----
        do_reset();
        if_ready_go = 1'b1;
        tick();
        tick();
        tick();                                   // ld in MEM, i2 in EXE, i3 in ID
        mem_dram_re = 1'b1;
        #1;
        chk("t3 c1 exe_to_mem_go", exe_to_mem_go[B], 1'b0);
        chk("t3 c1 pc_we",         pc_we[B],         1'b0);
        chk("t3 c1 mem_state",     mem_state[B],     4'd0);
        tick();
        chk("t3 c2 mem_valid",     mem_valid[B],     1'b1);
        chk("t3 c2 wb_valid",      wb_valid[B],      1'b0);
        chk("t3 c2 mem_state",     mem_state[B],     4'd1);
        chk("t3 c2 dram_cnt",      dram_cnt[B],      4'd1);
        chk("t3 c2 exe_to_mem_go", exe_to_mem_go[B], 1'b0);
        chk("t3 c2 if_to_id_go",   if_to_id_go[B],   1'b0);
        tick();
        chk("t3 c3 mem_valid",     mem_valid[B],     1'b1);
        chk("t3 c3 dram_cnt",      dram_cnt[B],      4'd2);
        chk("t3 c3 exe_to_mem_go", exe_to_mem_go[B], 1'b1);
        chk("t3 c3 pc_we",         pc_we[B],         1'b1);
        tick();
        mem_dram_re = 1'b0;
        chk("t3 ld wb_valid",      wb_valid[B],      1'b1);
        chk("t3 next mem_valid",   mem_valid[B],     1'b1);
        chk("t3 mem_state idle",   mem_state[B],     4'd0);
        chk("t3 dram_cnt clear",   dram_cnt[B],      4'd0);

        // ---- 4: taken branch in EXE while ID waits on x5 (no bypass) ----
        do_reset();
        if_ready_go = 1'b1;
        tick();                                   // add x5 in ID
        tick();                                   // add x5 in EXE, br in ID
        tick();                                   // add in MEM, br in EXE, user of x5 in ID
        mem_rd = 5'd5; mem_ref_we = 1'b1;
        exe_br_taken = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        chk("t4 pc_sel_br", pc_sel_br[C], 1'b1);
        chk("t4 pc_we",     pc_we[C],     1'b1);
        tick();
        exe_br_taken = 1'b0;
        chk("t4 id_valid squashed",  id_valid[C],  1'b0);
        chk("t4 exe_valid squashed", exe_valid[C], 1'b0);
        chk("t4 br mem_valid",       mem_valid[C], 1'b1);
        chk("t4 wb_valid",           wb_valid[C],  1'b1);
        #1;
        chk("t4 pc_sel_br after", pc_sel_br[C], 1'b0);

        // ---- 5: no bypass, x5 writer in WB; then a read of x0 ----
        do_reset();
        if_ready_go = 1'b1;
        tick();
        tick();
        tick();
        tick();                                   // add x5 in WB, reader in ID
        if_ready_go = 1'b0;
        wb_rd = 5'd5; wb_ref_we = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        chk("t5 wb stall",       id_stall[C], 1'b1);
        chk("t5 fwd no stall",   id_stall[A], 1'b0);
        tick();
        chk("t5 bubble exe_valid", exe_valid[C], 1'b0);
        chk("t5 held id_valid",    id_valid[C],  1'b1);
        wb_ref_we = 1'b0;
        #1;
        chk("t5 stall released", id_stall[C], 1'b0);
        wb_rd = 5'd0; wb_ref_we = 1'b1;
        id_rs1 = 5'd0;
        #1;
        chk("t5 x0 no stall",    id_stall[C], 1'b0);

        // ---- 6: reset in the middle of a DRAM wait ----
        do_reset();
        if_ready_go = 1'b1;
        tick();
        if_ready_go = 1'b0;
        tick();
        tick();                                   // ld in MEM
        mem_dram_re = 1'b1;
        tick();
        chk("t6 wait mem_state", mem_state[B], 4'd1);
        chk("t6 wait dram_cnt",  dram_cnt[B],  4'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6 rst mem_valid",  mem_valid[B], 1'b0);
        chk("t6 rst wb_valid",   wb_valid[B],  1'b0);
        chk("t6 rst mem_state",  mem_state[B], 4'd0);
        chk("t6 rst dram_cnt",   dram_cnt[B],  4'd0);
        #2;
        rst = 1'b1;
        clear_inputs();
        tick();
        chk("t6 post mem_state", mem_state[B], 4'd0);
        chk("t6 post dram_cnt",  dram_cnt[B],  4'd0);
        chk("t6 post mem_valid", mem_valid[B], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
